// File: rtl/onehot_demux.sv
// One-hot stream demultiplexer with a single registered holding stage.
// Optional saturating drop counter: ONEHOT_DEMUX_ERR_CNT_EN.
module onehot_demux #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_sel,
  input  logic [DW-1:0] in_data,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [N*DW-1:0] out_data,
  output logic          err,
  output logic [7:0]    err_cnt
);

  logic [N-1:0]  r_sel;
  logic [DW-1:0] r_data;
  logic          r_err;
  logic          w_full;
  logic          w_hs;
  logic          w_acc;
  logic          w_legal;

  // r_sel doubles as the full flag and the channel index
  assign w_full  = |r_sel;
  assign w_hs    = |(r_sel & out_ready);
  assign in_ready = aresetn & (~w_full | w_hs);
  assign w_acc   = in_valid & in_ready;
  assign w_legal = (in_sel != '0) &&
                   ((in_sel & (in_sel - 1'b1)) == '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sel  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_acc & ~w_legal;
      if (w_acc) begin
        r_sel  <= w_legal ? in_sel : '0;
        r_data <= in_data;
      end else if (w_hs) begin
        r_sel <= '0;
      end
    end
  end

  assign out_valid = r_sel;
  assign err       = r_err;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign out_data[(i+1)*DW-1 -: DW] = r_sel[i] ? r_data : '0;
  end

`ifdef ONEHOT_DEMUX_ERR_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (w_acc && !w_legal && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign err_cnt = r_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_onehot_demux.sv
// Directed vector bench for onehot_demux.
// Counter expectations follow ONEHOT_DEMUX_ERR_CNT_EN.
module tb_onehot_demux;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_sel;
  logic [DW-1:0] in_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [N*DW-1:0] out_data;
  logic          err;
  logic [7:0]    err_cnt;

  int checks = 0;
  int failures = 0;

  onehot_demux #(.DW(DW), .N(N)) dut (
    .clk(clk),
    .aresetn(aresetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sel(in_sel),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .err(err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  sel;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        ir;
    logic [3:0]  ov;
    logic [31:0] od;
    logic        er;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] ec(input int n);
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  function automatic vec_t mk(
    input logic v, input logic [3:0] sel, input logic [7:0] d,
    input logic [3:0] rdy, input logic ir, input logic [3:0] ov,
    input logic [31:0] od, input logic er, input logic [7:0] cnt);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.rdy = rdy; r.ir = ir;
    r.ov = ov; r.od = od; r.er = er; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] sel,
                       input logic [7:0] d, input logic [3:0] rdy);
    @(negedge clk);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    string s;
    drive(t.v, t.sel, t.d, t.rdy);
    #1;
    s = $sformatf("v%0d_in_ready", idx);
    chk(s, 32'(in_ready), 32'(t.ir));
    @(posedge clk);
    #1;
    s = $sformatf("v%0d_out_valid", idx);
    chk(s, 32'(out_valid), 32'(t.ov));
    s = $sformatf("v%0d_out_data", idx);
    chk(s, out_data, t.od);
    s = $sformatf("v%0d_err", idx);
    chk(s, 32'(err), 32'(t.er));
    s = $sformatf("v%0d_err_cnt", idx);
    chk(s, 32'(err_cnt), 32'(t.cnt));
  endtask

  initial begin
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;

    // idle and single held beat on channel 2
    vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 32'h0, 0, ec(0)));
    vecs.push_back(mk(1, 4'b0100, 8'hA5, 4'b0000, 1, 4'b0100, 32'h00A50000, 0, ec(0)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 0, 4'b0100, 32'h00A50000, 0, ec(0)));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b0100, 1, 4'b0000, 32'h0, 0, ec(0)));
    // back-to-back to channels 0, 3, 0
    vecs.push_back(mk(1, 4'b0001, 8'h01, 4'b1111, 1, 4'b0001, 32'h00000001, 0, ec(0)));
    vecs.push_back(mk(1, 4'b1000, 8'h02, 4'b1111, 1, 4'b1000, 32'h02000000, 0, ec(0)));
    vecs.push_back(mk(1, 4'b0001, 8'h03, 4'b1111, 1, 4'b0001, 32'h00000003, 0, ec(0)));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b1111, 1, 4'b0000, 32'h0, 0, ec(0)));
    // full on channel 1, wrong readies ignored
    vecs.push_back(mk(1, 4'b0010, 8'h5C, 4'b0000, 1, 4'b0010, 32'h00005C00, 0, ec(0)));
    vecs.push_back(mk(1, 4'b0001, 8'h77, 4'b1001, 0, 4'b0010, 32'h00005C00, 0, ec(0)));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b0010, 1, 4'b0000, 32'h0, 0, ec(0)));
    // illegal selects
    vecs.push_back(mk(1, 4'b0000, 8'h11, 4'b0000, 1, 4'b0000, 32'h0, 1, ec(1)));
    vecs.push_back(mk(1, 4'b0110, 8'h22, 4'b0000, 1, 4'b0000, 32'h0, 1, ec(2)));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 32'h0, 0, ec(2)));
    // illegal beat replacing a draining legal one
    vecs.push_back(mk(1, 4'b0100, 8'h33, 4'b0000, 1, 4'b0100, 32'h00330000, 0, ec(2)));
    vecs.push_back(mk(1, 4'b0011, 8'h44, 4'b0100, 1, 4'b0000, 32'h0, 1, ec(3)));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 32'h0, 0, ec(3)));

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h1);
    chk("idle_out_data", out_data, 32'h0);
    chk("idle_err", 32'(err), 32'h0);
    chk("idle_err_cnt", 32'(err_cnt), 32'h0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // saturation: 300 more illegal beats
    for (int i = 0; i < 300; i++) drive(1, 4'b1100, 8'(i), 4'b0000);
    @(posedge clk);
    #1;
    chk("sat_err", 32'(err), 32'h1);
    chk("sat_out_valid", 32'(out_valid), 32'h0);
    chk("sat_err_cnt", 32'(err_cnt), 32'(ec(303)));
    drive(0, 4'b0000, 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    chk("sat_err_low", 32'(err), 32'h0);
    chk("sat_err_cnt_hold", 32'(err_cnt), 32'(ec(303)));

    // asynchronous reset while full on channel 2
    drive(1, 4'b0100, 8'hC3, 4'b0000);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'h4);
    drive(0, 4'b0000, 8'h00, 4'b0100);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_out_data", out_data, 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h0);
    chk("async_err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    out_ready = 4'b0000;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    drive(1, 4'b1000, 8'h9E, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_rst_beat_valid", 32'(out_valid), 32'h8);
    chk("post_rst_beat_data", out_data, 32'h9E000000);
    chk("post_rst_err", 32'(err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
